// File: rtl/apb_mem_param.sv
// ---------------------------------------------------------------------------
// apb_mem_param
//
// Parametrised APB slave memory. Drop-in successor to the fixed 8-bit address /
// 32-bit data memory slave, adding:
//   - generic data width, address width, depth and wait-state count
//   - byte-strobe writes
//   - a write-protected low region (word indices 0..PROT_WORDS-1 while wprot_i=1)
//   - error responses for misaligned, out-of-range and protected accesses
//   - an 8-bit saturating count of error responses
//
// Ports:
//   pclk_i     in   1             clock, all logic on the rising edge
//   presetn_i  in   1             synchronous reset, active-low
//   psel_i     in   1             APB select
//   penable_i  in   1             APB enable (access phase)
//   pwrite_i   in   1             1 = write, 0 = read
//   paddr_i    in   ADDR_WIDTH    byte address
//   pwdata_i   in   DATA_WIDTH    write data
//   pstrb_i    in   DATA_WIDTH/8  write byte strobes
//   wprot_i    in   1             write-protect enable for the low region
//   prdata_o   out  DATA_WIDTH    read data, held until the next completed read
//   pready_o   out  1             transfer complete (one-cycle pulse)
//   pslverr_o  out  1             error response, valid while pready_o=1
//   err_cnt_o  out  8             saturating count of error responses
//
// Timing: the setup phase is captured in IDLE (or DONE for back-to-back
// transfers). The access phase then sees pready_o=0 for WAIT_CYCLES+1 cycles
// followed by a single cycle of pready_o=1.
// ---------------------------------------------------------------------------
module apb_mem_param #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 0,
    parameter int PROT_WORDS  = 4
) (
    input  logic                    pclk_i,
    input  logic                    presetn_i,
    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic                    pwrite_i,
    input  logic [ADDR_WIDTH-1:0]   paddr_i,
    input  logic [DATA_WIDTH-1:0]   pwdata_i,
    input  logic [DATA_WIDTH/8-1:0] pstrb_i,
    input  logic                    wprot_i,
    output logic [DATA_WIDTH-1:0]   prdata_o,
    output logic                    pready_o,
    output logic                    pslverr_o,
    output logic [7:0]              err_cnt_o
);

    // -----------------------------------------------------------------------
    // Derived constants
    // -----------------------------------------------------------------------
    localparam int STRB_W = DATA_WIDTH / 8;
    // Number of byte-offset bits inside a word (0 for an 8-bit bus).
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int MIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WCNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    localparam logic [ADDR_WIDTH-1:0] OFF_MASK   = ADDR_WIDTH'((1 << OFF_W) - 1);
    // Range limits are one bit wider than the address so that a memory that
    // fills the whole address space (DEPTH == 2**ADDR_WIDTH) still compares
    // correctly.
    localparam logic [ADDR_WIDTH:0]   DEPTH_LIM  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   PROT_LIM   = (ADDR_WIDTH + 1)'(PROT_WORDS);
    localparam logic [WCNT_W-1:0]     WAIT_LAST  = WCNT_W'(WAIT_CYCLES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]              state_q,   state_d;
    logic [WCNT_W-1:0]       wcnt_q,    wcnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
    logic                    write_q,   write_d;
    logic [DATA_WIDTH-1:0]   wdata_q,   wdata_d;
    logic [STRB_W-1:0]       strb_q,    strb_d;
    logic                    wprot_q,   wprot_d;
    logic [DATA_WIDTH-1:0]   prdata_q,  prdata_d;
    logic                    pready_q,  pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [7:0]              err_cnt_q, err_cnt_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    // -----------------------------------------------------------------------
    // Address decode of the captured transfer
    // -----------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] widx;
    logic [MIDX_W-1:0]     midx;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  protected_wr;
    logic                  acc_err;
    logic                  do_write;

    always_comb begin
        widx         = addr_q >> OFF_W;
        midx         = widx[MIDX_W-1:0];
        misaligned   = (addr_q & OFF_MASK) != '0;
        out_of_range = {1'b0, widx} >= DEPTH_LIM;
        protected_wr = write_q && wprot_q && ({1'b0, widx} < PROT_LIM);
        acc_err      = misaligned || out_of_range || protected_wr;
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        wprot_d   = wprot_q;
        prdata_d  = prdata_q;
        // pready/pslverr are single-cycle pulses; they are only raised on
        // the completing edge and cleared everywhere else.
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        err_cnt_d = err_cnt_q;
        do_write  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // psel with penable already high is a protocol violation
                // and is simply ignored.
                if (psel_i && !penable_i) begin
                    addr_d  = paddr_i;
                    write_d = pwrite_i;
                    wdata_d = pwdata_i;
                    strb_d  = pstrb_i;
                    wprot_d = wprot_i;
                    wcnt_d  = '0;
                    state_d = S_ACCESS;
                end
            end

            S_ACCESS: begin
                if (!psel_i) begin
                    // Master abandoned the transfer: no write, no response.
                    state_d = S_IDLE;
                end else if (penable_i) begin
                    if (wcnt_q == WAIT_LAST) begin
                        pready_d  = 1'b1;
                        pslverr_d = acc_err;
                        state_d   = S_DONE;
                        if (acc_err) begin
                            err_cnt_d = sat_inc8(err_cnt_q);
                            if (!write_q) begin
                                prdata_d = '0;
                            end
                        end else if (write_q) begin
                            do_write = 1'b1;
                        end else begin
                            prdata_d = mem_q[midx];
                        end
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
            end

            S_DONE: begin
                // A setup phase presented during the response cycle starts
                // the next transfer without passing through IDLE.
                if (psel_i && !penable_i) begin
                    addr_d  = paddr_i;
                    write_d = pwrite_i;
                    wdata_d = pwdata_i;
                    strb_d  = pstrb_i;
                    wprot_d = wprot_i;
                    wcnt_d  = '0;
                    state_d = S_ACCESS;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Control and response registers
    // -----------------------------------------------------------------------
    always_ff @(posedge pclk_i) begin
        if (!presetn_i) begin
            state_q   <= S_IDLE;
            wcnt_q    <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            wprot_q   <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            wprot_q   <= wprot_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Memory array: cleared on reset, byte-lane writes from captured data
    // -----------------------------------------------------------------------
    always_ff @(posedge pclk_i) begin
        if (!presetn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_write) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (strb_q[b]) begin
                    mem_q[midx][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign prdata_o  = prdata_q;
    assign pready_o  = pready_q;
    assign pslverr_o = pslverr_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: doc/apb_mem_param.md
Name: apb_mem_param

Overview:
- Parametrised APB slave memory: generic data width, address width, depth, wait-state count.
- Adds byte-strobe writes, a write-protected low region, and error responses for misaligned, out-of-range and protected accesses.
- Adds a saturating error counter.
- Sits on the APB peripheral bus as a drop-in successor to the fixed 8-bit-address / 32-bit-data memory slave.

Parameters:
- DATA_WIDTH, 32: data bus width; multiple of 8, at least 8.
- ADDR_WIDTH, 8: byte address width; DEPTH*(DATA_WIDTH/8) must be <= 2**ADDR_WIDTH.
- DEPTH, 64: number of DATA_WIDTH words.
- WAIT_CYCLES, 0: extra wait states inserted before pready_o.
- PROT_WORDS, 4: word indices 0..PROT_WORDS-1 are read-only while wprot_i=1.

Ports:
- pclk_i  in  1  clock; all logic on rising edge.
- presetn_i  in  1  synchronous reset, active-low.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable (access phase).
- pwrite_i  in  1  1 = write, 0 = read.
- paddr_i  in  ADDR_WIDTH  byte address.
- pwdata_i  in  DATA_WIDTH  write data.
- pstrb_i  in  DATA_WIDTH/8  write byte strobes.
- wprot_i  in  1  write-protect enable for the low region.
- prdata_o  out  DATA_WIDTH  read data.
- pready_o  out  1  transfer complete.
- pslverr_o  out  1  error response; valid only while pready_o=1.
- err_cnt_o  out  8  saturating count of error responses.

Behaviour:
Reset:
- Reset is synchronous (presetn_i=0 at a rising edge).
- Clears all memory words, prdata_o, pready_o, pslverr_o, err_cnt_o and the wait counter to 0; state goes to IDLE.
- Reset mid-transfer aborts it with no write and no response.

Addressing:
- Word index = paddr_i >> log2(DATA_WIDTH/8).
- Misaligned: low log2(DATA_WIDTH/8) address bits are nonzero.
- Out-of-range: index >= DEPTH.
- Protected: pwrite_i=1 and wprot_i=1 and index < PROT_WORDS.
- Any of the three gives an error.

FSM states: IDLE, ACCESS, DONE.

IDLE:
- On psel_i=1 and penable_i=0, capture paddr_i, pwrite_i, pwdata_i, pstrb_i, wprot_i; clear the wait counter; go to ACCESS.
- psel_i=1 with penable_i=1 in IDLE is a protocol violation: ignore it and stay in IDLE.

ACCESS:
- Each edge with psel_i=1 and penable_i=1 increments the wait counter.
- At the edge where the counter equals WAIT_CYCLES:
  - Perform the operation.
  - Set pready_o=1 and drive pslverr_o with the error flag.
  - Go to DONE.
- If psel_i=0 at any ACCESS edge: abort to IDLE, no write, pready_o stays 0.
- Write: each byte lane with its strobe set is updated from the captured pwdata; other lanes are unchanged. pstrb all zero is legal: no change, no error.
- Read: prdata_o is loaded with the memory word. pstrb is ignored.
- On error: no memory update; read drives prdata_o=0; err_cnt_o increments and saturates at 255.

Latency:
- The access phase sees pready_o=0 for exactly WAIT_CYCLES+1 cycles, then pready_o=1 for exactly one cycle.

DONE:
- Next edge clears pready_o and pslverr_o.
- If psel_i=1 and penable_i=0 at that edge, capture the new setup and go to ACCESS (back-to-back transfers, no idle cycle). Otherwise go to IDLE.

Output holds:
- prdata_o holds its value until the next completed read or reset.
- Writes never change prdata_o.
- Captured values are used for the whole transfer; bus changes during ACCESS are ignored apart from the psel_i abort.

Test Plan:
(DATA_WIDTH=32, DEPTH=64, WAIT_CYCLES=2, PROT_WORDS=4)
1. Reset, write addr 0x10 data 0x0000000F strobe 0xF, then read 0x10 -> prdata_o=0x0000000F, pslverr_o=0, and 3 low-pready access cycles on each transfer.
2. Write 0x14 data 0xAABBCCDD strobe 0xF, then write 0x14 data 0x11223344 strobe 0x5, then read 0x14 -> 0xAA22CC44.
3. wprot_i=1, write 0x04 data 0x1234 -> pslverr_o=1 and err_cnt_o=1; read 0x04 -> 0, no error. Repeat with wprot_i=0 -> write succeeds, read returns 0x1234.
4. Read 0x11 (misaligned) and read 0x100-equivalent index 64 (ADDR_WIDTH=9 build) -> both pslverr_o=1, prdata_o=0, err_cnt_o increments per error. Force 300 errors -> err_cnt_o=255.
5. Back-to-back: write 0x20 then a setup phase in the DONE cycle for a read of 0x20 -> read completes with no intervening IDLE cycle and returns the written data.
6. Drop psel_i during ACCESS of write 0x24 data 0xFF -> no pready_o, memory unchanged (read 0x24 -> 0). presetn_i=0 mid-ACCESS -> outputs 0, state IDLE.
